// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period helper
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

    // clk cycles per serial bit; clk_fre is in MHz, truncating divide.
    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a delay flop
// for falling-edge detection. Everything resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_pin,
    output logic rx_s,
    output logic fe
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= rx_pin;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rx_s = sync_q;
    assign fe   = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling on a clk-cycle counter, byte delivered
// on a valid/ready handshake with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_fre   = 100,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int          CYCLE = calc_cycle(clk_fre, baud_rate);
    localparam logic [15:0] HALF  = 16'(CYCLE / 2);
    localparam logic [15:0] LAST  = 16'(CYCLE - 1);

    logic rx_s;
    logic fe;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_pin (rx_pin),
        .rx_s   (rx_s),
        .fe     (fe)
    );

    rx_state_t   state_q;
    logic [15:0] cycle_cnt_q;
    logic [15:0] cycle_cnt_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        valid_q;
    logic        frame_err_q;
    logic        overrun_q;

    assign cycle_cnt_d = cycle_cnt_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && rx_data_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (fe) begin
                        state_q     <= S_START;
                        cycle_cnt_q <= 16'd0;
                    end
                end
                S_START: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    if (cycle_cnt_q == HALF && rx_s) begin
                        state_q     <= S_IDLE;
                        cycle_cnt_q <= 16'd0;
                    end else if (cycle_cnt_q == LAST) begin
                        state_q     <= S_DATA;
                        cycle_cnt_q <= 16'd0;
                        bit_cnt_q   <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (cycle_cnt_q == HALF) begin
                        shift_q[bit_cnt_q] <= rx_s;
                    end
                    if (cycle_cnt_q == LAST) begin
                        cycle_cnt_q <= 16'd0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_d;
                    end
                end
                S_STOP: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (cycle_cnt_q == HALF) begin
                        cycle_cnt_q <= 16'd0;
                        if (rx_s) begin
                            rx_data_q <= shift_q;
                            valid_q   <= 1'b1;
                            overrun_q <= valid_q & ~rx_data_ready;
                            state_q   <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cycle_cnt_q <= 16'd0;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = valid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clk per bit: a serial line model drives
// rx_pin while a posedge monitor logs accepted bytes and flag pulses.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         rise_cyc = 0;
    int         valid_cycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         got_n = 0;
    logic [7:0] got [0:63];
    logic       valid_prev = 1'b0;

    uart_rx #(
        .clk_fre   (1),
        .baud_rate (125000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Values read here are the pre-edge outputs, i.e. what the DUT itself sees.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        valid_prev <= rx_data_valid;
        if (rx_data_valid && !valid_prev) rise_cyc <= cyc;
        if (rx_data_valid) valid_cycles <= valid_cycles + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (rx_data_valid && rx_data_ready && got_n < 64) begin
            got[got_n] <= rx_data;
            got_n      <= got_n + 1;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_pin = bits[i];
            repeat (8) @(negedge clk);
        end
        rx_pin = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx_pin = 1'b1;
        rx_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
        checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_data_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_single;
        int g0, v0, f0, o0, c0;
        g0 = got_n; v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
        rx_data_ready = 1'b1;
        c0 = cyc;
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (got_n - g0 !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_n - g0); end
        checks++; if (got[g0] !== 8'h55) begin errors++; $display("FAIL single_data got %h exp 55", got[g0]); end
        checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL single_valid_width got %0d exp 1", valid_cycles - v0); end
        checks++; if (rise_cyc - c0 !== 80) begin errors++; $display("FAIL single_latency got %0d exp 80", rise_cyc - c0); end
        checks++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin errors++; $display("FAIL single_flags got fe=%0d ov=%0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
        $display("single: byte %h latency %0d", got[g0], rise_cyc - c0);
    endtask

    task automatic test_back_to_back;
        int g0, o0;
        g0 = got_n; o0 = ov_cnt;
        rx_data_ready = 1'b0;
        fork
            begin
                send_frame(8'hA3, 1'b1);
                send_frame(8'h3C, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    for (int i = 0; i < 200; i++) begin
                        if (rx_data_valid) break;
                        @(negedge clk);
                    end
                    checks++;
                    if (!rx_data_valid) begin errors++; $display("FAIL b2b_timeout got valid=0 exp 1 (byte %0d)", k); end
                    rx_data_ready = 1'b1;
                    @(negedge clk);
                    rx_data_ready = 1'b0;
                end
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (got_n - g0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_n - g0); end
        checks++; if (got[g0] !== 8'hA3) begin errors++; $display("FAIL b2b_first got %h exp a3", got[g0]); end
        checks++; if (got[g0+1] !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h exp 3c", got[g0+1]); end
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL b2b_overrun got %0d exp 0", ov_cnt - o0); end
        $display("back_to_back: bytes %h %h", got[g0], got[g0+1]);
    endtask

    task automatic test_glitch;
        int g0, v0, f0;
        g0 = got_n; v0 = valid_cycles; f0 = fe_cnt;
        rx_data_ready = 1'b1;
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        rx_pin = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", valid_cycles - v0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d exp 0", fe_cnt - f0); end
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (got_n - g0 !== 1 || got[g0] !== 8'h81) begin errors++; $display("FAIL glitch_next got n=%0d %h exp 1 81", got_n - g0, got[g0]); end
        $display("glitch: following byte %h", got[g0]);
    endtask

    task automatic test_frame_err;
        int g0, v0, f0;
        g0 = got_n; v0 = valid_cycles; f0 = fe_cnt;
        rx_data_ready = 1'b1;
        send_frame(8'hF0, 1'b0);
        rx_pin = 1'b0;
        repeat (20) @(negedge clk);
        rx_pin = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", fe_cnt - f0); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", valid_cycles - v0); end
        send_frame(8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (got_n - g0 !== 1 || got[g0] !== 8'h0F) begin errors++; $display("FAIL ferr_next got n=%0d %h exp 1 0f", got_n - g0, got[g0]); end
        $display("frame_err: pulses %0d, following byte %h", fe_cnt - f0, got[g0]);
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ov_cnt;
        rx_data_ready = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ov_cnt - o0); end
        checks++; if (rx_data !== 8'h34) begin errors++; $display("FAIL ovr_data got %h exp 34", rx_data); end
        checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", rx_data_valid); end
        rx_data_ready = 1'b1;
        @(negedge clk);
        checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", rx_data_valid); end
        $display("overrun: pulses %0d data %h", ov_cnt - o0, rx_data);
    endtask

    task automatic test_reset_midframe;
        int g0;
        logic [7:0] b;
        rx_data_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rx_data_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b exp 1", rx_data_valid); end
        b = 8'h99;
        rx_pin = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_pin = b[i];
            repeat (8) @(negedge clk);
        end
        rx_pin = b[3];
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rx_data !== 8'h00 || rx_data_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got data=%h v=%b fe=%b ov=%b exp 00 0 0 0", rx_data, rx_data_valid, frame_err, overrun);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        g0 = got_n;
        rx_data_ready = 1'b1;
        send_frame(8'h66, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (got_n - g0 !== 1 || got[g0] !== 8'h66) begin errors++; $display("FAIL rstmid_next got n=%0d %h exp 1 66", got_n - g0, got[g0]); end
        $display("reset_midframe: following byte %h", got[g0]);
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first. Mirror of the transmit path; pairs with it for a full-duplex serial link.
- Samples the asynchronous rx_pin and locates each bit by mid-bit sampling on a clk-cycle counter.
- Presents each received byte on a valid/ready handshake. Flags framing errors and overruns.

Parameters:
- clk_fre, 100, clk frequency in MHz.
- baud_rate, 9600, line rate in bit/s.
- CYCLE (localparam), clk_fre*1000000/baud_rate, clk cycles per bit. Integer divide. Must satisfy 4 <= CYCLE <= 65535.
- HALF (localparam), CYCLE/2, mid-bit sample offset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- rx_pin  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte, stable while rx_data_valid=1.
- rx_data_valid  output  1  byte available; held until accepted.
- rx_data_ready  input  1  consumer accepts when valid&ready on a rising clk edge.
- frame_err  output  1  1-clk pulse: stop bit sampled 0.
- overrun  output  1  1-clk pulse: new byte overwrote an unaccepted byte.

Behaviour:
- Reset values: rx_data=0, rx_data_valid=0, frame_err=0, overrun=0. State=S_IDLE. Counters=0. Synchronizer flops=1.
- Input conditioning: 2-flop synchronizer gives rx_s. A third flop gives rx_d. Falling edge fe = rx_d & ~rx_s. Pin-to-rx_s latency is 2 clk.
- cycle_cnt is 16 bits; bit_cnt is 3 bits; shift is an 8-bit register.
- S_IDLE:
  - On fe, go to S_START with cycle_cnt=0.
  - Otherwise stay in S_IDLE. An rx_s held low without an edge is ignored.
- S_START:
  - cycle_cnt increments every clk.
  - At cycle_cnt==HALF, sample rx_s. If rx_s=1, it is a false start: go to S_IDLE, discard the frame, raise no flags.
  - At cycle_cnt==CYCLE-1, go to S_DATA with cycle_cnt=0 and bit_cnt=0.
- S_DATA:
  - At cycle_cnt==HALF, write rx_s into shift[bit_cnt] (LSB first).
  - At cycle_cnt==CYCLE-1, set cycle_cnt=0. If bit_cnt==7, go to S_STOP; otherwise increment bit_cnt.
- S_STOP:
  - At cycle_cnt==HALF, sample rx_s.
  - If rx_s=1: on the next edge, rx_data<=shift and rx_data_valid<=1. Go directly to S_IDLE without waiting out the rest of the stop bit, so a back-to-back start edge is caught.
  - If rx_s=0: frame_err pulses for 1 clk and rx_data/valid are untouched. Go to S_BREAK.
- S_BREAK: wait until rx_s==1, then go to S_IDLE. This prevents false starts during a break or a stuck-low line.
- Handshake:
  - rx_data_valid clears on the edge where valid&ready=1.
  - Delivery while valid=1 and ready=0: rx_data is overwritten, valid stays 1, overrun pulses for 1 clk.
  - Delivery in the same cycle as acceptance: the old byte counts as consumed, the new byte is loaded, valid stays 1, no overrun.
- Latency: valid rises 1 clk after the stop-bit mid-sample, about 9.5 bit times plus 3 clk after the pin's falling edge.
- A reset asserted mid-frame aborts immediately and returns all outputs to reset values. After release, a line held low is not a start. Only a fresh high-to-low edge starts a frame.
- Baud tolerance: with mid-bit sampling, the receiver tolerates about ±4% cumulative clock mismatch.

Decomposition:
- Package uart_pkg holds:
  - state encoding: S_IDLE=3'd0, S_START=1, S_DATA=2, S_STOP=3, S_BREAK=4;
  - a function computing CYCLE from clk_fre and baud_rate, shared with the transmitter.
- One sub-module, uart_rx_sync: the 2-flop synchronizer plus edge flop, with outputs rx_s and fe. All reset values are 1.

Test Plan:
- Setup for all scenarios: override clk_fre=1 and baud_rate=125000, giving CYCLE=8 and HALF=4. Drive rx_pin from a bit-accurate serial model.
- Single byte: send 0x55 with ready=1 -> valid pulses for 1 clk, rx_data=0x55, frame_err=0, overrun=0.
- Back-to-back bytes: send 0xA3 then 0x3C with no idle gap, and ready held low until each valid is seen -> 0xA3 then 0x3C delivered in order, no overrun.
- Glitch and false start: drive rx_pin low for 3 clk, then high -> state returns to S_IDLE, no valid, no frame_err.
  - A following 0x81 frame is still received correctly.
- Framing error: send 0xF0 with stop bit = 0, and hold the line low for 20 clk -> frame_err pulses once, valid stays 0.
  - After the line returns high, a following 0x0F is received correctly.
- Overrun: hold ready=0 and send 0x12 then 0x34 -> overrun pulses once at the second delivery, rx_data=0x34, valid=1.
  - Raising ready clears valid on the next edge.
- Reset mid-frame: assert rst_n=0 during bit 3 of 0x99, release while the line is high, then send 0x66 -> only 0x66 is delivered, and all outputs are 0 during reset.
